// File: rtl/ddr_axi_mem_tester.sv
// rtl/ddr_axi_mem_tester.sv - AXI4 write/readback pattern tester for a DDR controller user port
// Define MEM_TEST_LFSR_EN to replace the incrementing beat pattern with a per-beat Galois LFSR.
module ddr_axi_mem_tester #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       NUM_BEATS  = 16,
  parameter int unsigned       NUM_BURSTS = 4,
  parameter logic [31:0]       SEED       = 32'h0
) (
  input  logic                  SYSCLK,
  input  logic                  NSYSRESET,
  input  logic                  START,
  input  logic                  CTRLR_READY,
  output logic [ADDR_W-1:0]     M_AWADDR,
  output logic [7:0]            M_AWLEN,
  output logic [2:0]            M_AWSIZE,
  output logic [1:0]            M_AWBURST,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_W-1:0]     M_WDATA,
  output logic [DATA_W/8-1:0]   M_WSTRB,
  output logic                  M_WLAST,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDR_W-1:0]     M_ARADDR,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_W-1:0]     M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [15:0]           ERR_COUNT
);

  localparam int unsigned       LANES      = DATA_W / 32;
  localparam int unsigned       BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(NUM_BEATS * (DATA_W / 8));
  localparam logic [2:0]        AXSIZE     = 3'($clog2(DATA_W / 8));
  localparam logic [7:0]        AXLEN      = 8'(NUM_BEATS - 1);
  localparam logic [8:0]        LAST_BEAT  = 9'(NUM_BEATS - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
`ifdef MEM_TEST_LFSR_EN
  localparam logic [31:0]       GEN_SEED   = SEED | 32'h1;
`else
  localparam logic [31:0]       GEN_SEED   = SEED;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  function automatic logic [31:0] gen_next(input logic [31:0] s);
`ifdef MEM_TEST_LFSR_EN
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
`else
    return s + 32'h1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] lanes(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  state_t              state_q;
  logic                rdy_meta_q, rdy_sync_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [8:0]          beat_q, skip_q;
  logic [BURST_W-1:0]  burst_q;
  logic [31:0]         gen_q;
  logic                busy_q, done_q;
  logic [15:0]         err_q;

  logic [31:0]         gen_d;
  logic [15:0]         err_d;
  logic                beat_last;
  logic                rd_bad;

  // gen_q always holds the pattern word of the beat currently being written or expected.
  assign gen_d     = gen_next(gen_q);
  assign err_d     = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
  assign beat_last = (beat_q == LAST_BEAT);
  assign rd_bad    = (M_RDATA != lanes(gen_q)) || (M_RRESP != 2'b00) || (M_RLAST != beat_last);

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q    <= S_IDLE;
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
      addr_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      beat_q     <= '0;
      skip_q     <= '0;
      burst_q    <= '0;
      gen_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      rdy_meta_q <= CTRLR_READY;
      rdy_sync_q <= rdy_meta_q;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q <= S_WAIT_RDY;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= '0;
            gen_q   <= GEN_SEED;
            beat_q  <= '0;
            burst_q <= '0;
            skip_q  <= '0;
          end
        end
        S_WAIT_RDY: begin
          if (rdy_sync_q) begin
            state_q   <= S_WR_ADDR;
            addr_q    <= BASE_ADDR;
            awvalid_q <= 1'b1;
          end
        end
        S_WR_ADDR: begin
          if (M_AWREADY) begin
            state_q   <= S_WR_DATA;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= lanes(gen_q);
            wlast_q   <= (LAST_BEAT == 9'd0);
            beat_q    <= '0;
          end
        end
        S_WR_DATA: begin
          if (M_WREADY) begin
            gen_q <= gen_d;
            if (wlast_q) begin
              state_q  <= S_WR_RESP;
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              wdata_q <= lanes(gen_d);
              beat_q  <= beat_q + 9'd1;
              wlast_q <= ((beat_q + 9'd1) == LAST_BEAT);
            end
          end
        end
        S_WR_RESP: begin
          if (M_BVALID) begin
            bready_q <= 1'b0;
            if (M_BRESP != 2'b00) err_q <= err_d;
            if (burst_q == LAST_BURST) begin
              state_q   <= S_RD_ADDR;
              burst_q   <= '0;
              gen_q     <= GEN_SEED;
              addr_q    <= BASE_ADDR;
              arvalid_q <= 1'b1;
            end else begin
              state_q   <= S_WR_ADDR;
              burst_q   <= burst_q + BURST_W'(1);
              addr_q    <= addr_q + STRIDE;
              awvalid_q <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          // A burst cut short by an early RLAST leaves the generator behind; catch it up first.
          if (skip_q != 9'd0) begin
            gen_q     <= gen_d;
            skip_q    <= skip_q - 9'd1;
            arvalid_q <= (skip_q == 9'd1);
          end else if (arvalid_q && M_ARREADY) begin
            state_q   <= S_RD_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
          end
        end
        S_RD_DATA: begin
          if (M_RVALID) begin
            gen_q <= gen_d;
            if (rd_bad) err_q <= err_d;
            if (M_RLAST || beat_last) begin
              rready_q <= 1'b0;
              beat_q   <= '0;
              if (burst_q == LAST_BURST) begin
                state_q <= S_DONE;
                burst_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_RD_ADDR;
                burst_q   <= burst_q + BURST_W'(1);
                addr_q    <= addr_q + STRIDE;
                skip_q    <= LAST_BEAT - beat_q;
                arvalid_q <= beat_last;
              end
            end else begin
              beat_q <= beat_q + 9'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = AXLEN;
  assign M_AWSIZE  = AXSIZE;
  assign M_AWBURST = 2'b01;
  assign M_AWVALID = awvalid_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = '1;
  assign M_WLAST   = wlast_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = AXLEN;
  assign M_ARSIZE  = AXSIZE;
  assign M_ARBURST = 2'b01;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = done_q && (err_q == 16'd0);
  assign ERR_COUNT = err_q;

endmodule
